// File: rtl/wm_pkg.sv
// wm_pkg: shared FSM state encoding and default LFSR tap masks for the watermark generator
package wm_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [7:0]  TAPS8  = 8'hB8;
   localparam logic [15:0] TAPS16 = 16'hB400;
endpackage

// File: rtl/wm_lfsr.sv
// wm_lfsr: Fibonacci LFSR with seed load and STEPS-step advance per enable
//   clk, rst_n : clock, async active-low reset (state resets to 1)
//   load, seed : load seed (a zero seed becomes 1 so the register never locks up)
//   adv        : advance STEPS shifts in one cycle
//   q          : current register contents
module wm_lfsr #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter int               STEPS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             adv,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] nxt;
   always_comb begin
      nxt = q;
      for (int s = 0; s < STEPS; s++) nxt = {nxt[WIDTH-2:0], ^(nxt & TAPS)};
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= WIDTH'(1);
      else if (load) q <= (seed == '0) ? WIDTH'(1) : seed;
      else if (adv) q <= nxt;
endmodule

// File: rtl/wm_sequence_gen.sv
// wm_sequence_gen: LFSR watermark symbol generator with valid/ready handshake
//   start, key, length, mode : begin a run (sampled in IDLE); mode 1 whitens bits
//   abort                    : cancel a run in progress, no done pulse
//   wm_data, wm_valid, wm_ready : symbol stream handshake
//   busy, done, count        : run active, one-cycle completion pulse, symbols accepted
import wm_pkg::*;
module wm_sequence_gen #(
   parameter int               WIDTH    = 16,
   parameter int               OUT_BITS = 2,
   parameter int               LEN_W    = 16,
   parameter logic [WIDTH-1:0] TAPS     = WIDTH'(TAPS16)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    key,
   input  logic [LEN_W-1:0]    length,
   input  logic                mode,
   input  logic                abort,
   output logic [OUT_BITS-1:0] wm_data,
   output logic                wm_valid,
   input  logic                wm_ready,
   output logic                busy,
   output logic                done,
   output logic [LEN_W-1:0]    count
);
   state_t           state, nxt_state;
   logic [LEN_W-1:0] len_q, cnt_inc;
   logic             mode_q, load, adv, last;
   logic [WIDTH-1:0] q;
   assign busy     = state == RUN;
   assign wm_valid = busy;
   assign done     = state == DONE;
   assign load     = (state == IDLE) & start;
   assign adv      = wm_valid & wm_ready & ~abort;
   assign cnt_inc  = count + 1'b1;
   assign last     = cnt_inc == len_q;
   wm_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(OUT_BITS)) u_lfsr (
      .clk(clk), .rst_n(rst_n), .load(load), .seed(key), .adv(adv), .q(q)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt_state;
   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    nxt_state = start ? ((length == '0) ? DONE : RUN) : IDLE;
         RUN:     nxt_state = abort ? IDLE : (adv && last) ? DONE : RUN;
         default: nxt_state = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count  <= '0;
         len_q  <= '0;
         mode_q <= 1'b0;
      end else if (load) begin
         count  <= '0;
         len_q  <= length;
         mode_q <= mode;
      end else if (adv) begin
         count  <= cnt_inc;
      end
   // Whitening folds each low bit with its mirror bit from the top of the register.
   always_comb begin
      wm_data = '0;
      for (int i = 0; i < OUT_BITS; i++) wm_data[i] = busy & (q[i] ^ (mode_q & q[WIDTH-1-i]));
   end
endmodule

// File: tb/tb_wm_sequence_gen.sv
module tb_wm_sequence_gen;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        d_start = 0, d_mode = 0, d_abort = 0, d_ready = 0;
   logic [15:0] d_key = 0, d_len = 0, d_count;
   logic [1:0]  d_data;
   logic        d_valid, d_busy, d_done;
   logic        p_start = 0, p_mode = 0, p_abort = 0, p_ready = 0;
   logic [7:0]  p_key = 0;
   logic [15:0] p_len = 0, p_count;
   logic [0:0]  p_data;
   logic        p_valid, p_busy, p_done;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   wm_sequence_gen u_dut (
      .clk(clk), .rst_n(rst_n), .start(d_start), .key(d_key), .length(d_len), .mode(d_mode),
      .abort(d_abort), .wm_data(d_data), .wm_valid(d_valid), .wm_ready(d_ready),
      .busy(d_busy), .done(d_done), .count(d_count)
   );

   wm_sequence_gen #(.WIDTH(8), .OUT_BITS(1), .LEN_W(16), .TAPS(8'hB8)) u_p8 (
      .clk(clk), .rst_n(rst_n), .start(p_start), .key(p_key), .length(p_len), .mode(p_mode),
      .abort(p_abort), .wm_data(p_data), .wm_valid(p_valid), .wm_ready(p_ready),
      .busy(p_busy), .done(p_done), .count(p_count)
   );

   typedef struct {
      logic [15:0] key;
      logic [15:0] len;
      logic        mode;
      int          stall_at;
      int          abort_at;
      logic [1:0]  first;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] m16(input logic [15:0] q);
      logic [15:0] r = q;
      for (int s = 0; s < 2; s++) r = {r[14:0], ^(r & 16'hB400)};
      return r;
   endfunction

   function automatic logic [1:0] sym16(input logic [15:0] q, input logic mode);
      return mode ? {q[1] ^ q[14], q[0] ^ q[15]} : q[1:0];
   endfunction

   task automatic run16(input vec_t v);
      logic [15:0] q = (v.key == 16'h0) ? 16'h1 : v.key;
      @(negedge clk);
      d_start = 1; d_key = v.key; d_len = v.len; d_mode = v.mode; d_ready = 1;
      @(negedge clk);
      d_start = 0; d_key = 16'h0;
      for (int n = 0; n < int'(v.len); n++) begin
         chk("valid", d_valid, 1);
         chk("sym", d_data, sym16(q, v.mode));
         chk("count", d_count, n);
         chk("done_in_run", d_done, 0);
         if (n == 0) chk("first_sym", d_data, v.first);
         if (n == v.stall_at) begin
            d_ready = 0; d_start = 1; d_key = 16'h5555;
            repeat (5) begin
               @(negedge clk);
               chk("stall_sym", d_data, sym16(q, v.mode));
               chk("stall_count", d_count, n);
               chk("stall_valid", d_valid, 1);
            end
            d_ready = 1; d_start = 0; d_key = 16'h0;
         end
         if (n == v.abort_at) begin
            d_abort = 1;
            @(negedge clk);
            d_abort = 0;
            chk("abort_busy", d_busy, 0);
            chk("abort_valid", d_valid, 0);
            chk("abort_count", d_count, n);
            chk("abort_done", d_done, 0);
            @(negedge clk);
            chk("abort_done2", d_done, 0);
            return;
         end
         @(negedge clk);
         q = m16(q);
      end
      chk("end_done", d_done, 1);
      chk("end_valid", d_valid, 0);
      chk("end_count", d_count, v.len);
      @(negedge clk);
      chk("idle_done", d_done, 0);
      chk("idle_busy", d_busy, 0);
      chk("hold_count", d_count, v.len);
   endtask

   initial begin
      tbl[0] = '{16'hACE1, 16'd8,  1'b0,  2, -1, 2'b01};
      tbl[1] = '{16'h1234, 16'd16, 1'b1, -1, -1, 2'b00};
      tbl[2] = '{16'h0000, 16'd0,  1'b0, -1, -1, 2'b00};
      tbl[3] = '{16'hBEEF, 16'd8,  1'b0, -1,  3, 2'b11};
      tbl[4] = '{16'h0000, 16'd5,  1'b1, -1, -1, 2'b01};
      tbl[5] = '{16'hFFFF, 16'd4,  1'b0,  1, -1, 2'b11};
      tbl[6] = '{16'hFFFF, 16'd3,  1'b1, -1, -1, 2'b00};
      tbl[7] = '{16'h0001, 16'd1,  1'b0,  0, -1, 2'b01};

      #12;
      chk("rst_valid", d_valid, 0);
      chk("rst_busy", d_busy, 0);
      chk("rst_done", d_done, 0);
      chk("rst_data", d_data, 0);
      chk("rst_count", d_count, 0);
      chk("rst_lfsr", u_dut.u_lfsr.q, 16'h0001);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 8; i++) run16(tbl[i]);

      begin
         logic [7:0] q8 = 8'h01;
         @(negedge clk);
         p_start = 1; p_key = 8'h00; p_len = 16'd255; p_ready = 1;
         @(negedge clk);
         p_start = 0;
         for (int n = 0; n < 255; n++) begin
            chk("p8_valid", p_valid, 1);
            chk("p8_sym", p_data, q8[0]);
            chk("p8_done", p_done, 0);
            @(negedge clk);
            q8 = {q8[6:0], ^(q8 & 8'hB8)};
         end
         chk("p8_end_done", p_done, 1);
         chk("p8_end_valid", p_valid, 0);
         chk("p8_count", p_count, 255);
         chk("p8_lfsr", u_p8.u_lfsr.q, 8'h01);
         @(negedge clk);
         chk("p8_done_once", p_done, 0);
      end

      @(negedge clk);
      d_start = 1; d_key = 16'hACE1; d_len = 16'd8; d_mode = 0; d_ready = 1;
      @(negedge clk);
      d_start = 0;
      repeat (3) @(negedge clk);
      chk("ar_busy_before", d_busy, 1);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("ar_valid", d_valid, 0);
      chk("ar_busy", d_busy, 0);
      chk("ar_done", d_done, 0);
      chk("ar_data", d_data, 0);
      chk("ar_count", d_count, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (4) begin
         @(negedge clk);
         chk("ar_no_done", d_done, 0);
         chk("ar_idle", d_busy, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
